// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter producing a registered one-hot grant with encoded index and valid.
// A per-grant ack quota forces rotation among requesters that hold their request for long bursts.
module rr_onehot_arbiter #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 ack,
    output logic [N-1:0]         grant,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(MAX_HOLD) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] QUOTA_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;

    logic [IDX_W-1:0] cur;
    logic [IDX_W-1:0] next_ptr;
    logic             withdraw;
    logic             quota_hit;
    pick_t            pick_idle;
    pick_t            pick_rel;

    // First requester at or after the start point, wrapping; scanning backwards
    // lets the closest candidate overwrite farther ones.
    function automatic pick_t rr_pick(input logic [N-1:0] r, input logic [IDX_W-1:0] start);
        pick_t            res;
        int               j;
        logic [IDX_W-1:0] jj;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(start) + k;
            if (j >= N) begin
                j = j - N;
            end
            jj = IDX_W'(j);
            if (r[jj]) begin
                res.found = 1'b1;
                res.idx   = jj;
            end
        end
        return res;
    endfunction

    always_comb begin
        cur       = gnt_idx_q;
        next_ptr  = (cur == LAST_IDX) ? '0 : cur + IDX_W'(1);
        withdraw  = !req[cur];
        quota_hit = ack && (beat_cnt_q == QUOTA_LAST);
        pick_idle = rr_pick(req, ptr_q);
        pick_rel  = rr_pick(req, next_ptr);
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        beat_cnt_d  = beat_cnt_q;
        grant_d     = grant_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;

        case (state_q)
            IDLE: begin
                if (pick_idle.found) begin
                    state_d     = GRANT;
                    grant_d     = N'(1) << pick_idle.idx;
                    gnt_idx_d   = pick_idle.idx;
                    gnt_valid_d = 1'b1;
                    beat_cnt_d  = '0;
                end
            end
            GRANT: begin
                // Release re-arbitrates in the same edge so a waiting requester sees no bubble.
                if (withdraw || quota_hit) begin
                    ptr_d      = next_ptr;
                    beat_cnt_d = '0;
                    if (pick_rel.found) begin
                        grant_d     = N'(1) << pick_rel.idx;
                        gnt_idx_d   = pick_rel.idx;
                        gnt_valid_d = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        grant_d     = '0;
                        gnt_idx_d   = '0;
                        gnt_valid_d = 1'b0;
                    end
                end else if (ack) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                grant_d     = '0;
                gnt_idx_d   = '0;
                gnt_valid_d = 1'b0;
                beat_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            beat_cnt_q  <= '0;
            grant_q     <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            grant_q     <= grant_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign grant     = grant_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Self-checking bench for rr_onehot_arbiter: a per-cycle reference model plus
// directed scenarios with hand-computed grants.
module tb_rr_onehot_arbiter;

    localparam int N        = 8;
    localparam int MAX_HOLD = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic         ack;
    logic [N-1:0] grant;
    logic         gnt_valid;
    logic [2:0]   gnt_idx;

    int errors = 0;
    int checks = 0;

    // Reference model: owner index (-1 when nobody holds), rotation start, acks taken.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_beats = 0;

    rr_onehot_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ack       (ack),
        .grant     (grant),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int search(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_beats = 0;
        end else if (m_owner < 0) begin
            if (req != '0) begin
                m_owner = search(req, m_ptr);
                m_beats = 0;
            end
        end else if (!req[m_owner] || (ack && (m_beats + 1 == MAX_HOLD))) begin
            m_ptr   = (m_owner + 1) % N;
            m_beats = 0;
            m_owner = search(req, m_ptr);
        end else if (ack) begin
            m_beats = m_beats + 1;
        end
    end

    // Every cycle, away from the active edge, the outputs must match the model.
    always @(negedge clk) begin
        logic [N-1:0] exp_grant;
        logic         exp_valid;
        logic [2:0]   exp_idx;
        exp_grant = (m_owner < 0) ? '0 : N'(1) << m_owner;
        exp_valid = (m_owner >= 0);
        exp_idx   = (m_owner < 0) ? 3'd0 : 3'(m_owner);
        checks++;
        if (grant !== exp_grant || gnt_valid !== exp_valid || gnt_idx !== exp_idx) begin
            errors++;
            $display("[TB] FAIL model_cycle t=%0t: got grant=%h valid=%b idx=%0d, expected grant=%h valid=%b idx=%0d",
                     $time, grant, gnt_valid, gnt_idx, exp_grant, exp_valid, exp_idx);
        end
    end

    task automatic applyStimulus(input logic [N-1:0] r, input logic a);
        req = r;
        ack = a;
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [N-1:0] eg,
                               input logic ev, input logic [2:0] ei);
        checks++;
        if (grant !== eg || gnt_valid !== ev || gnt_idx !== ei) begin
            errors++;
            $display("[TB] FAIL %s: got grant=%h valid=%b idx=%0d, expected grant=%h valid=%b idx=%0d",
                     name, grant, gnt_valid, gnt_idx, eg, ev, ei);
        end
    endtask

    task automatic doReset();
        req   = '0;
        ack   = 1'b0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    logic [N-1:0] rot_exp [9];
    logic [N-1:0] ack6_exp [5];
    logic [N-1:0] ack6_req [5];

    initial begin
        rot_exp  = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h80, 8'h80, 8'h80, 8'h80, 8'h01};
        ack6_req = '{8'h02, 8'h06, 8'h06, 8'h06, 8'h06};
        ack6_exp = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h04};

        rst_n = 1'b0;
        req   = 8'hFF;
        ack   = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_values", 8'h00, 1'b0, 3'd0);
        rst_n = 1'b1;
        applyStimulus(8'hFF, 1'b0);
        checkOutput("reset_first_grant", 8'h01, 1'b1, 3'd0);

        doReset();
        applyStimulus(8'h08, 1'b1);
        checkOutput("solo_first", 8'h08, 1'b1, 3'd3);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'h08, 1'b1);
            checkOutput($sformatf("solo_hold_%0d", i), 8'h08, 1'b1, 3'd3);
        end

        doReset();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(8'h81, 1'b1);
            checkOutput($sformatf("rotation_%0d", i), rot_exp[i], 1'b1,
                        (rot_exp[i] == 8'h80) ? 3'd7 : 3'd0);
        end

        doReset();
        applyStimulus(8'h34, 1'b0);
        checkOutput("withdraw_setup", 8'h04, 1'b1, 3'd2);
        applyStimulus(8'h30, 1'b1);
        checkOutput("withdraw_switch", 8'h10, 1'b1, 3'd4);

        doReset();
        applyStimulus(8'h04, 1'b0);
        checkOutput("withdraw_solo_setup", 8'h04, 1'b1, 3'd2);
        applyStimulus(8'h00, 1'b0);
        checkOutput("withdraw_to_idle", 8'h00, 1'b0, 3'd0);

        doReset();
        applyStimulus(8'h20, 1'b0);
        applyStimulus(8'h20, 1'b1);
        applyStimulus(8'h20, 1'b1);
        checkOutput("midreset_setup", 8'h20, 1'b1, 3'd5);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_async", 8'h00, 1'b0, 3'd0);
        rst_n = 1'b1;
        applyStimulus(8'h21, 1'b0);
        checkOutput("midreset_ptr_zero", 8'h01, 1'b1, 3'd0);

        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'h00, 1'b1);
            checkOutput($sformatf("idle_ack_%0d", i), 8'h00, 1'b0, 3'd0);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(ack6_req[i], 1'b1);
            checkOutput($sformatf("idle_ack_quota_%0d", i), ack6_exp[i], 1'b1,
                        (ack6_exp[i] == 8'h04) ? 3'd2 : 3'd1);
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
